// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the MM-stage data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned MEM_WORD_W = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    DM_S_IDLE = 2'd0,
    DM_S_BUSY = 2'd1,
    DM_S_DONE = 2'd2
  } dm_state_e;

  // Request payload captured at acceptance and replayed at the access edge.
  typedef struct packed {
    logic                  write;
    logic [MEM_WORD_W-1:0] wdata;
  } dm_req_t;

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port word array: synchronous write, synchronous read-on-enable, no reset.
module dmem_responder_array
  import dmem_responder_pkg::*;
#(
  parameter  int unsigned DEPTH = 1024,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [MEM_WORD_W-1:0] wdata,
  output logic [MEM_WORD_W-1:0] rdata
);

  logic [MEM_WORD_W-1:0] mem [DEPTH];

  // Read register only updates on a read, so it holds between loads.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MM-stage data-memory responder: fixed-latency load/store with pipeline stall.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mm_mem_read,
  input  logic                  mm_mem_write,
  input  logic [31:0]           mm_addr,
  input  logic [MEM_WORD_W-1:0] mm_wdata,
  output logic [MEM_WORD_W-1:0] mm_rdata,
  output logic                  mm_ready,
  output logic                  mem_stall,
  output logic                  mm_misalign
);

  localparam int unsigned AW = $clog2(DEPTH);

  dm_state_e             state;
  logic [CNT_W-1:0]      cnt;
  dm_req_t               req_q;
  logic [AW-1:0]         idx_q;
  logic                  rd_seen;
  logic                  access_c;
  logic [MEM_WORD_W-1:0] arr_rdata;
  logic                  unused_addr_c;

  assign unused_addr_c = ^mm_addr[31:AW+2];
  assign access_c      = (state == DM_S_BUSY) && (cnt == '0);
  assign mem_stall     = (mm_mem_read | mm_mem_write) & ~mm_ready;

  // Array read register has no reset; present zero until the first completed load.
  assign mm_rdata = rd_seen ? arr_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DM_S_IDLE;
      cnt         <= '0;
      req_q       <= '0;
      idx_q       <= '0;
      rd_seen     <= 1'b0;
      mm_ready    <= 1'b0;
      mm_misalign <= 1'b0;
    end else begin
      mm_ready <= 1'b0;
      case (state)
        DM_S_IDLE: begin
          if (mm_mem_read || mm_mem_write) begin
            req_q.write <= mm_mem_write;
            req_q.wdata <= mm_wdata;
            idx_q       <= mm_addr[AW+1:2];
            cnt         <= CNT_W'(LATENCY - 1);
            state       <= DM_S_BUSY;
            if (mm_addr[1:0] != 2'b00) mm_misalign <= 1'b1;
          end
        end
        DM_S_BUSY: begin
          if (cnt == '0) begin
            state    <= DM_S_DONE;
            mm_ready <= 1'b1;
            if (!req_q.write) rd_seen <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DM_S_DONE: state <= DM_S_IDLE;
        default:   state <= DM_S_IDLE;
      endcase
    end
  end

  // Write/read happens exactly at the BUSY->DONE edge; reset drops state and so the enable.
  dmem_responder_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .en    (access_c),
    .we    (req_q.write),
    .addr  (idx_q),
    .wdata (req_q.wdata),
    .rdata (arr_rdata)
  );

endmodule
